tx_fifo: RTL and testbench
==========================

// Module: tx_fifo
// PURPOSE
//  - Transmit FIFO of the SSP block: buffers bytes written over the APB-style
//    write port (PSEL/PWRITE/PWDATA) and presents them in order to the
//    transmit logic, which pops one entry per SENT cycle.
//  - Reports FIFO full to the host through SSPTXINTR and FIFO empty to the
//    transmit logic through SENT_E.
// PARAMETERS
//  - WIDTH  8  data width in bits
//  - DEPTH  4  number of entries; must be a power of 2, minimum 2
// PORTS
//  - PCLK      in   1      clock; all state updates on its rising edge
//  - CLEAR_B   in   1      reset; synchronous and active-high
//  - PSEL      in   1      chip select; must be high for a write
//  - PWRITE    in   1      write strobe
//  - PWDATA    in   WIDTH  write data
//  - SENT      in   1      pop request from the transmit logic
//  - TxDATA    out  WIDTH  head-of-FIFO data for the transmit logic
//  - SSPTXINTR out  1      FIFO full (1 = full, host must stop writing)
//  - SENT_E    out  1      FIFO empty (1 = nothing to transmit)
// BEHAVIOUR
//  - Reset (CLEAR_B=1 at a PCLK edge):
//    - write pointer, read pointer and count go to 0; all entries go to 0.
//    - Outputs: TxDATA=0, SSPTXINTR=0, SENT_E=1.
//    - Reset wins over any same-cycle push or pop.
//  - Storage: DEPTH x WIDTH register array, circular wr_ptr/rd_ptr of
//    clog2(DEPTH) bits, and a count of clog2(DEPTH)+1 bits.
//  - push = PSEL & PWRITE & ~full: the edge writes PWDATA to mem[wr_ptr] and
//    increments wr_ptr (wraps DEPTH-1 -> 0).
//  - pop = SENT & ~empty: the edge increments rd_ptr (wraps).
//  - SENT is level-sensitive: held high, it pops one entry per clock.
//  - full = (count==DEPTH); empty = (count==0). Both come from registered
//    count only; an incoming pop does not admit a push while full.
//  - Count update: push only +1; pop only -1; push and pop together leaves
//    count unchanged (both pointers advance).
//  - A write while full is dropped silently. SENT while empty is ignored.
//  - TxDATA = mem[rd_ptr], combinational first-word fall-through. A byte
//    pushed at edge N appears on TxDATA after edge N if the FIFO was empty.
//    When empty, TxDATA shows the stale entry at rd_ptr (0 after reset).
//  - SSPTXINTR = full. SENT_E = empty. Both change only after a PCLK edge.
//  - PSEL=0 or PWRITE=0 blocks push regardless of PWDATA.
// STRUCTURE
//  - Shared package ssp_pkg: SSP_DATA_W=8 and TXFIFO_DEPTH=4 constants
//    (reused by the RxFIFO), plus function clog2.
//  - Single module; no sub-module. Pointer/count logic is one always block
//    and the storage array is another.
// TESTING (PCLK period 40)
//  - Reset: CLEAR_B=1 for 1 edge -> SENT_E=1, SSPTXINTR=0, TxDATA=0x00.
//  - Write 0x55 with PSEL=1, PWRITE=1 for 1 edge -> SENT_E=0, TxDATA=0x55.
//  - Fill 0x55,0xAA,0x02,0x03 with SENT=0 -> SSPTXINTR=1 after the 4th edge.
//    A 5th write of 0xFC is dropped, and after draining TxDATA never shows 0xFC.
//  - From full, SENT=1 for 4 edges -> TxDATA steps 0x55,0xAA,0x02,0x03.
//    Then SENT_E=1 and SSPTXINTR=0; a further SENT leaves count at 0.
//  - Simultaneous push/pop at count=2 -> count stays 2 and order is
//    preserved across the pointer wrap (push 6+ bytes and check FIFO order).
//  - CLEAR_B=1 mid-stream with 3 entries -> next cycle SENT_E=1 and TxDATA=0.
//    The next write of 0x11 appears as TxDATA=0x11.

Source files
------------

// File: rtl/ssp_pkg.sv
// Shared SSP constants and helpers, used by both the transmit and receive FIFOs.
package ssp_pkg;

  localparam int unsigned SSP_DATA_W   = 8;
  localparam int unsigned TXFIFO_DEPTH = 4;

  // Ceiling log2 for sizing pointers; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// SSP transmit FIFO: host bytes in via the APB-style write port,
// popped in order by the transmit logic with first-word fall-through.
module tx_fifo
  import ssp_pkg::*;
#(
  parameter int unsigned WIDTH = SSP_DATA_W,
  parameter int unsigned DEPTH = TXFIFO_DEPTH
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic             SENT,
  output logic [WIDTH-1:0] TxDATA,
  output logic             SSPTXINTR,
  output logic             SENT_E
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Flags come only from the registered count, so a same-cycle pop never frees a slot for a push.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));
  assign push  = PSEL & PWRITE & ~full;
  assign pop   = SENT & ~empty;

  // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge PCLK) begin
    if (CLEAR_B) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, cleared on reset so the stale head reads 0 afterwards.
  always_ff @(posedge PCLK) begin
    if (CLEAR_B) begin
      mem <= '{default: '0};
    end else if (push) begin
      mem[wr_ptr] <= PWDATA;
    end
  end

  assign TxDATA    = mem[rd_ptr];
  assign SSPTXINTR = full;
  assign SENT_E    = empty;

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: vector table plus a queue scoreboard
// tracking FIFO contents, with hand-written wrap/full/reset sequences.
module tb_tx_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         PCLK;
  logic         CLEAR_B;
  logic         PSEL;
  logic         PWRITE;
  logic [W-1:0] PWDATA;
  logic         SENT;
  logic [W-1:0] TxDATA;
  logic         SSPTXINTR;
  logic         SENT_E;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] sb_q[$];

  typedef struct {
    logic         clr;
    logic         psel;
    logic         pwrite;
    logic [W-1:0] wdata;
    logic         sent;
    logic [W-1:0] exp_data;
    logic         exp_full;
    logic         exp_empty;
  } vec_t;

  tx_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .SENT      (SENT),
    .TxDATA    (TxDATA),
    .SSPTXINTR (SSPTXINTR),
    .SENT_E    (SENT_E)
  );

  initial PCLK = 1'b0;
  always #20 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, update scoreboard from pre-edge state, check after the edge.
  task automatic step(input logic clr, input logic psel, input logic pwrite,
                      input logic [W-1:0] wdata, input logic sent);
    bit do_push;
    bit do_pop;
    @(negedge PCLK);
    CLEAR_B = clr;
    PSEL    = psel;
    PWRITE  = pwrite;
    PWDATA  = wdata;
    SENT    = sent;
    #5;
    if (clr) begin
      sb_q.delete();
    end else begin
      do_push = psel && pwrite && (sb_q.size() < D);
      do_pop  = sent && (sb_q.size() > 0);
      if (do_pop) begin
        chk("pop_data", 32'(TxDATA), 32'(sb_q[0]));
        void'(sb_q.pop_front());
      end
      if (do_push) sb_q.push_back(wdata);
    end
    @(posedge PCLK);
    #1;
    chk("sb_empty", 32'(SENT_E), 32'(sb_q.size() == 0));
    chk("sb_full", 32'(SSPTXINTR), 32'(sb_q.size() == D));
    if (sb_q.size() > 0) chk("sb_head", 32'(TxDATA), 32'(sb_q[0]));
    if (TxDATA === 8'hFC) chk("no_dropped_byte", 32'(TxDATA), 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    CLEAR_B = 1'b1;
    PSEL    = 1'b0;
    PWRITE  = 1'b0;
    PWDATA  = '0;
    SENT    = 1'b0;

    //          clr   psel  pwrite data   sent  exp_data full  empty
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 8'h55, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 8'h55, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 8'h55, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hFC, 1'b0, 8'h55, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 8'h55, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 8'h55, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].psel, vecs[i].pwrite, vecs[i].wdata, vecs[i].sent);
      chk($sformatf("vec%0d_data", i), 32'(TxDATA), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_full", i), 32'(SSPTXINTR), 32'(vecs[i].exp_full));
      chk($sformatf("vec%0d_empty", i), 32'(SENT_E), 32'(vecs[i].exp_empty));
    end

    // Simultaneous push/pop at occupancy 2 across several pointer wraps.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h02, 1'b0);
    for (int k = 3; k <= 10; k++) begin
      step(1'b0, 1'b1, 1'b1, 8'(k), 1'b1);
      chk("pp_not_empty", 32'(SENT_E), 32'h0);
      chk("pp_not_full", 32'(SSPTXINTR), 32'h0);
      chk("pp_head", 32'(TxDATA), 32'(k - 1));
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("pp_drain1", 32'(TxDATA), 32'h0A);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("pp_drained", 32'(SENT_E), 32'h1);

    // Full with push+pop together: pop proceeds, push dropped, occupancy 3.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 8'(8'h20 + k), 1'b0);
    chk("full_again", 32'(SSPTXINTR), 32'h1);
    step(1'b0, 1'b1, 1'b1, 8'hFC, 1'b1);
    chk("full_pp_not_full", 32'(SSPTXINTR), 32'h0);
    chk("full_pp_head", 32'(TxDATA), 32'h21);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("full_pp_last", 32'(TxDATA), 32'h23);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("full_pp_empty", 32'(SENT_E), 32'h1);

    // Reset mid-stream with 3 entries and a push/pop pending: reset wins.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 8'(8'h40 + k), 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h99, 1'b1);
    chk("clr_empty", 32'(SENT_E), 32'h1);
    chk("clr_full", 32'(SSPTXINTR), 32'h0);
    chk("clr_data", 32'(TxDATA), 32'h00);
    step(1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    chk("clr_write", 32'(TxDATA), 32'h11);
    chk("clr_write_ne", 32'(SENT_E), 32'h0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
